cam_lookup: RTL and testbench

CAM_LOOKUP -- requirements
Module: cam_lookup

---
 rtl/cam_pkg.sv | 11 +
 rtl/cam_word.sv | 24 ++
 rtl/cam_lookup.sv | 118 +++++++++++
 tb/tb_cam_lookup.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default sizing for the content-addressable lookup block.
package cam_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    RESPOND
  } state_t;
endpackage

// File: rtl/cam_word.sv
// One stored CAM word with write enable and qualified equality match.
module cam_word
  import cam_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             compare_en,
  input  logic [WIDTH-1:0] key,
  output logic             match
);

  logic [WIDTH-1:0] data;

  // Payload bits are don't-care until the owning valid bit is set.
  always_ff @(posedge clk) begin
    if (write_en) data <= write_data;
  end

  assign match = compare_en & (&(data ~^ key));

endmodule

// File: rtl/cam_lookup.sv
// Small FIFO-allocated CAM with a 2-cycle search and a held result.
module cam_lookup
  import cam_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     write_valid_i,
  output logic                     write_ready_o,
  input  logic [WIDTH-1:0]         write_data_i,
  input  logic                     search_valid_i,
  output logic                     search_ready_o,
  input  logic [WIDTH-1:0]         search_data_i,
  input  logic                     clear_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic                     result_hit_o,
  output logic [$clog2(DEPTH)-1:0] result_index_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t state, state_next;

  logic [WIDTH-1:0] key_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] match_q;
  logic [AW-1:0]    ptr_q;
  logic [AW:0]      occ_q;
  logic [AW-1:0]    idx;
  logic             hit;

  logic idle;
  logic search_fire;
  logic write_fire;
  logic clear_fire;

  assign idle        = (state == IDLE);
  assign search_fire = search_valid_i & idle;
  assign write_fire  = write_valid_i & write_ready_o;
  assign clear_fire  = clear_i & idle;

  assign search_ready_o = idle;
  assign write_ready_o  = idle & ~search_valid_i;

  always_ff @(posedge clk) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (search_fire) state_next = COMPARE;
      COMPARE: state_next = RESPOND;
      RESPOND: if (result_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (search_fire) key_q <= search_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset_i)               match_q <= '0;
    else if (state == COMPARE) match_q <= match;
  end

  // Clear beats a same-cycle write; a full CAM overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
      occ_q   <= '0;
    end else if (clear_fire) begin
      valid_q <= '0;
      ptr_q   <= '0;
      occ_q   <= '0;
    end else if (write_fire) begin
      valid_q[ptr_q] <= 1'b1;
      ptr_q          <= ptr_q + 1'b1;
      if (occ_q != FULL) occ_q <= occ_q + 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    cam_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk       (clk),
      .write_en  (write_fire & ~clear_fire & (ptr_q == AW'(g))),
      .write_data(write_data_i),
      .compare_en(valid_q[g] & (state == COMPARE)),
      .key       (key_q),
      .match     (match[g])
    );
  end

  always_comb begin
    hit = |match_q;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_q[i]) idx = AW'(i);
    end
  end

  assign result_valid_o = (state == RESPOND);
  assign result_hit_o   = result_valid_o & hit;
  assign result_index_o = result_valid_o ? idx : '0;
  assign occupancy_o    = occ_q;

endmodule

// File: tb/tb_cam_lookup.sv
// Directed self-checking bench for cam_lookup.
module tb_cam_lookup;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       write_valid_i;
  logic       write_ready_o;
  logic [7:0] write_data_i;
  logic       search_valid_i;
  logic       search_ready_o;
  logic [7:0] search_data_i;
  logic       clear_i;
  logic       result_valid_o;
  logic       result_ready_i;
  logic       result_hit_o;
  logic [2:0] result_index_o;
  logic [3:0] occupancy_o;

  int checks   = 0;
  int failures = 0;

  cam_lookup #(
    .WIDTH(8),
    .DEPTH(8)
  ) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .write_valid_i (write_valid_i),
    .write_ready_o (write_ready_o),
    .write_data_i  (write_data_i),
    .search_valid_i(search_valid_i),
    .search_ready_o(search_ready_o),
    .search_data_i (search_data_i),
    .clear_i       (clear_i),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_hit_o  (result_hit_o),
    .result_index_o(result_index_o),
    .occupancy_o   (occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    write_valid_i = 1'b1;
    write_data_i  = d;
    tick();
    write_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  // Search with fixed timing: result must be absent after 1 cycle, present after 2.
  task automatic run_search(input logic [7:0] k, output logic lat_ok,
                            output logic h, output logic [2:0] ix);
    logic v1;
    search_valid_i = 1'b1;
    search_data_i  = k;
    tick();
    search_valid_i = 1'b0;
    v1 = result_valid_o;
    tick();
    lat_ok = !v1 && result_valid_o;
    h  = result_hit_o;
    ix = result_index_o;
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b exp=0", result_valid_o);
    end
    checks++;
    if (occupancy_o !== 4'd0) begin
      failures++;
      $display("FAIL reset_occ got=%0d exp=0", occupancy_o);
    end
    checks++;
    if ({result_hit_o, result_index_o} !== 4'd0) begin
      failures++;
      $display("FAIL reset_result got=%0b/%0d exp=0/0", result_hit_o, result_index_o);
    end
    checks++;
    if ({search_ready_o, write_ready_o} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready got=%0b exp=11", {search_ready_o, write_ready_o});
    end
  endtask

  task automatic test_empty();
    logic l, h;
    logic [2:0] ix;
    run_search(8'h5A, l, h, ix);
    checks++;
    if (l !== 1'b1) begin
      failures++;
      $display("FAIL empty_latency got=%0b exp=1", l);
    end
    checks++;
    if ({h, ix} !== 4'b0000) begin
      failures++;
      $display("FAIL empty_result got=%0b/%0d exp=0/0", h, ix);
    end
    checks++;
    if (occupancy_o !== 4'd0) begin
      failures++;
      $display("FAIL empty_occ got=%0d exp=0", occupancy_o);
    end
  endtask

  task automatic test_basic();
    logic l, h;
    logic [2:0] ix;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    run_search(8'h22, l, h, ix);
    checks++;
    if ({l, h, ix} !== 5'b11_001) begin
      failures++;
      $display("FAIL basic_hit got=%0b/%0b/%0d exp=1/1/1", l, h, ix);
    end
    checks++;
    if (occupancy_o !== 4'd3) begin
      failures++;
      $display("FAIL basic_occ got=%0d exp=3", occupancy_o);
    end
  endtask

  task automatic test_wrap();
    logic l, h;
    logic [2:0] ix;
    do_clear();
    checks++;
    if (occupancy_o !== 4'd0) begin
      failures++;
      $display("FAIL clear_occ got=%0d exp=0", occupancy_o);
    end
    for (int i = 0; i < 9; i++) write_word(8'(i));
    checks++;
    if (occupancy_o !== 4'd8) begin
      failures++;
      $display("FAIL wrap_occ got=%0d exp=8", occupancy_o);
    end
    run_search(8'h00, l, h, ix);
    checks++;
    if ({h, ix} !== 4'b0000) begin
      failures++;
      $display("FAIL wrap_old_miss got=%0b/%0d exp=0/0", h, ix);
    end
    run_search(8'h08, l, h, ix);
    checks++;
    if ({h, ix} !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_new_hit got=%0b/%0d exp=1/0", h, ix);
    end
    run_search(8'h07, l, h, ix);
    checks++;
    if ({h, ix} !== 4'b1111) begin
      failures++;
      $display("FAIL wrap_last_hit got=%0b/%0d exp=1/7", h, ix);
    end
  endtask

  task automatic test_duplicate();
    logic l, h;
    logic [2:0] ix;
    do_clear();
    write_word(8'hAA);
    write_word(8'h55);
    write_word(8'hAA);
    run_search(8'hAA, l, h, ix);
    checks++;
    if ({h, ix} !== 4'b1000) begin
      failures++;
      $display("FAIL dup_lowest got=%0b/%0d exp=1/0", h, ix);
    end
    run_search(8'h55, l, h, ix);
    checks++;
    if ({h, ix} !== 4'b1001) begin
      failures++;
      $display("FAIL dup_other got=%0b/%0d exp=1/1", h, ix);
    end
  endtask

  task automatic test_backpressure();
    search_valid_i = 1'b1;
    search_data_i  = 8'hAA;
    tick();
    search_valid_i = 1'b0;
    tick();
    search_valid_i = 1'b1;
    search_data_i  = 8'h55;
    write_valid_i  = 1'b1;
    write_data_i   = 8'h77;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({result_valid_o, result_hit_o, result_index_o,
           search_ready_o, write_ready_o} !== 7'b11_000_00) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%0b/%0b/%0d/%0b/%0b exp=1/1/0/0/0", c,
                 result_valid_o, result_hit_o, result_index_o,
                 search_ready_o, write_ready_o);
      end
      tick();
    end
    checks++;
    if (occupancy_o !== 4'd3) begin
      failures++;
      $display("FAIL hold_frozen_occ got=%0d exp=3", occupancy_o);
    end
    write_valid_i  = 1'b0;
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    checks++;
    if ({result_valid_o, search_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL release_idle got=%0b exp=01", {result_valid_o, search_ready_o});
    end
    tick();
    search_valid_i = 1'b0;
    checks++;
    if ({result_valid_o, search_ready_o} !== 2'b00) begin
      failures++;
      $display("FAIL next_compare got=%0b exp=00", {result_valid_o, search_ready_o});
    end
    tick();
    checks++;
    if ({result_valid_o, result_hit_o, result_index_o} !== 5'b11_001) begin
      failures++;
      $display("FAIL next_result got=%0b/%0b/%0d exp=1/1/1",
               result_valid_o, result_hit_o, result_index_o);
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    search_valid_i = 1'b1;
    search_data_i  = 8'hAA;
    tick();
    search_valid_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (result_valid_o) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midreset_valid got=%0b exp=0", seen);
    end
    checks++;
    if (occupancy_o !== 4'd0) begin
      failures++;
      $display("FAIL midreset_occ got=%0d exp=0", occupancy_o);
    end
  endtask

  task automatic test_clear_write();
    logic l, h;
    logic [2:0] ix;
    write_word(8'h11);
    write_word(8'h22);
    clear_i       = 1'b1;
    write_valid_i = 1'b1;
    write_data_i  = 8'h99;
    tick();
    clear_i       = 1'b0;
    write_valid_i = 1'b0;
    checks++;
    if (occupancy_o !== 4'd0) begin
      failures++;
      $display("FAIL clearwr_occ got=%0d exp=0", occupancy_o);
    end
    run_search(8'h99, l, h, ix);
    checks++;
    if ({h, ix} !== 4'b0000) begin
      failures++;
      $display("FAIL clearwr_miss got=%0b/%0d exp=0/0", h, ix);
    end
    write_word(8'h44);
    run_search(8'h44, l, h, ix);
    checks++;
    if ({h, ix, occupancy_o} !== 8'b1000_0001) begin
      failures++;
      $display("FAIL clearwr_ptr got=%0b/%0d/%0d exp=1/0/1", h, ix, occupancy_o);
    end
  endtask

  initial begin
    reset_i        = 1'b1;
    write_valid_i  = 1'b0;
    write_data_i   = '0;
    search_valid_i = 1'b0;
    search_data_i  = '0;
    clear_i        = 1'b0;
    result_ready_i = 1'b0;
    test_reset();
    test_empty();
    test_basic();
    test_wrap();
    test_duplicate();
    test_backpressure();
    test_reset_mid();
    test_clear_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
